inst_buffer_mw: RTL and testbench
=================================

Name: inst_buffer_mw

Overview:
Parametrised multi-width instruction buffer between the ICache fetch stage and the decoder. Replaces fixed-lane, per-lane queues with a single compacting circular buffer. Each fetch packet writes only its valid instructions, tagged with a per-instruction PC. The decoder drains up to DECODE_WIDTH instructions per cycle, with a variable consume count, so partial issue does not stall the fetch group.

Parameters:
FETCH_WIDTH, 4, max instructions accepted per enqueue
DECODE_WIDTH, 4, max instructions presented per cycle
DEPTH, 16, instruction slots; power of 2, >= FETCH_WIDTH + DECODE_WIDTH
BP_MARGIN, 4, back-pressure asserted when free slots < BP_MARGIN + FETCH_WIDTH

Ports:
clock  in  1  single clock; all state updates on rising edge
reset  in  1  synchronous, active-low reset (0 = reset, sampled on clock edge)
io_in_ready  out  1  free slots >= FETCH_WIDTH
io_in_valid  in  1  fetch packet valid
io_in_bits_inst  in  FETCH_WIDTH*32  instructions; lane i at [32i+31:32i]
io_in_bits_size  in  3  number of valid lanes, from lane 0 upward
io_in_bits_pc  in  32  PC of lane 0
io_out_valid  out  1  count != 0
io_out_bits_inst  out  DECODE_WIDTH*32  oldest instructions; slot 0 = oldest
io_out_bits_pc  out  DECODE_WIDTH*32  PC of each presented instruction
io_out_bits_valid  out  DECODE_WIDTH  bit j = (count > j)
io_out_deq_cnt  in  3  instructions consumed by decoder this cycle
io_status_count  out  clog2(DEPTH+1)  occupied slots
io_status_back_pressure  out  1  free slots < BP_MARGIN + FETCH_WIDTH
io_status_full  out  1  count == DEPTH
io_flush  in  1  discard all contents

Behaviour:
- State:
  - head and tail pointers, PTR_W = clog2(DEPTH) bits, wrap modulo DEPTH.
  - count register.
  - inst[DEPTH] and pc[DEPTH] storage. Storage is not reset.
- Reset (reset == 0 at edge):
  - head = tail = count = 0.
  - Outputs after reset: io_out_valid = 0, io_out_bits_valid = 0, io_in_ready = 1, io_status_count = 0, io_status_back_pressure = 0, io_status_full = 0.
  - io_out_bits_inst and io_out_bits_pc are don't-care while the corresponding valid bit is 0.
  - Reset overrides flush, enqueue and dequeue.
- Enqueue fires when io_in_valid && io_in_ready.
  - n_enq = min(io_in_bits_size, FETCH_WIDTH).
  - Lane i < n_enq is written to slot (tail+i) mod DEPTH, with pc = io_in_bits_pc + 4*i (32-bit wrap).
  - tail += n_enq.
  - size = 0 completes the handshake and writes nothing.
- Dequeue:
  - n_deq = min(io_out_deq_cnt, DECODE_WIDTH, count), so an over-request is clamped and never underflows.
  - head += n_deq.
  - io_out_deq_cnt is ignored when io_out_valid = 0.
- Output is combinational from registered state. Output slot j shows slot (head+j) mod DEPTH.
- Latency: an instruction enqueued at edge k is visible on io_out at cycle k+1. There is no enq-to-deq bypass.
- Simultaneous enqueue and dequeue:
  - Dequeue acts on the pre-edge contents.
  - count_next = count + n_enq - n_deq.
  - io_in_ready uses the current count only; no credit is taken from a same-cycle dequeue.
- Flush (io_flush = 1, reset inactive):
  - Next state: head = tail = count = 0.
  - Any same-cycle enqueue or dequeue is dropped.
  - io_in_ready is unaffected in the flush cycle.
- Wrap-around: writes and reads crossing slot DEPTH-1 continue at slot 0, with PC continuity preserved.
- Full: io_in_ready = 0 whenever DEPTH - count < FETCH_WIDTH. A packet is never partially accepted.
- Empty: io_out_valid = 0 and all io_out_bits_valid = 0.
- Invariants (assertions): count <= DEPTH; count == (tail - head) mod DEPTH, except when count == DEPTH with head == tail.

Test Plan:
- Reset then single enq: size = 3, pc = 0x1000, insts A/B/C → next cycle io_out_bits_valid = 0b0111, pcs 0x1000/0x1004/0x1008, io_status_count = 3.
- Partial issue: buffer holds 6; deq_cnt = 2 for three cycles → slot 0 shows instructions 3 then 5; count 6→4→2→0; third cycle consumes only 2.
- Fill: enq size = 4 each cycle, no deq → count 4, 8, 12; io_in_ready = 0 at count = 16 (full = 1). Back-pressure asserts once count > 8 with the defaults (free < 8), i.e. at count = 12.
- Wrap: advance head/tail to 14, enq size = 4, pc = 0x2000 → slots 14, 15, 0, 1 written; out pcs 0x2000..0x200C in order; tail = 2.
- Simultaneous: count = 4, enq size = 4 plus deq_cnt = 4 → count stays 4, output shows the new packet next cycle. Repeat with deq_cnt = 7 → clamped to 4.
- Flush/reset mid-stream: count = 10, assert io_flush together with a valid enq → count = 0, io_out_valid = 0 next cycle. Repeat with reset = 0 while io_flush = 0 → same result.

Source files
------------

// File: rtl/inst_buffer_mw.sv
// -----------------------------------------------------------------------------
// inst_buffer_mw
// Compacting circular instruction buffer between the ICache fetch stage and
// the decoder. Each fetch packet writes only its valid lanes into consecutive
// slots, and each slot is tagged with its own PC. The decoder sees the oldest
// DECODE_WIDTH entries and consumes a variable number of them each cycle.
//
// Ports
//   clock                    rising-edge clock
//   reset                    synchronous active-low reset
//   io_in_ready              at least FETCH_WIDTH slots free
//   io_in_valid              fetch packet valid
//   io_in_bits_inst          FETCH_WIDTH x 32-bit instructions (lane 0 low)
//   io_in_bits_size          number of valid lanes, counted from lane 0
//   io_in_bits_pc            PC of lane 0; lane i is pc + 4*i
//   io_out_valid             buffer not empty
//   io_out_bits_inst         DECODE_WIDTH oldest instructions (slot 0 oldest)
//   io_out_bits_pc           PC of each presented instruction
//   io_out_bits_valid        bit j set when more than j entries are held
//   io_out_deq_cnt           instructions consumed this cycle (clamped)
//   io_status_count          occupied slots
//   io_status_back_pressure  free slots < BP_MARGIN + FETCH_WIDTH
//   io_status_full           count == DEPTH
//   io_flush                 discard all contents
// -----------------------------------------------------------------------------
module inst_buffer_mw #(
  parameter int FETCH_WIDTH  = 4,
  parameter int DECODE_WIDTH = 4,
  parameter int DEPTH        = 16,
  parameter int BP_MARGIN    = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  output logic                           io_in_ready,
  input  logic                           io_in_valid,
  input  logic [FETCH_WIDTH*32-1:0]      io_in_bits_inst,
  input  logic [2:0]                     io_in_bits_size,
  input  logic [31:0]                    io_in_bits_pc,
  output logic                           io_out_valid,
  output logic [DECODE_WIDTH*32-1:0]     io_out_bits_inst,
  output logic [DECODE_WIDTH*32-1:0]     io_out_bits_pc,
  output logic [DECODE_WIDTH-1:0]        io_out_bits_valid,
  input  logic [2:0]                     io_out_deq_cnt,
  output logic [$clog2(DEPTH+1)-1:0]     io_status_count,
  output logic                           io_status_back_pressure,
  output logic                           io_status_full,
  input  logic                           io_flush
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Payload storage; never reset, validity is tracked by count_q alone.
  logic [31:0] inst_q [DEPTH];
  logic [31:0] pc_q   [DEPTH];

  logic [31:0]      free_s;
  logic [31:0]      deq_req_s;
  logic             enq_fire_s;
  logic [CNT_W-1:0] n_enq_s;
  logic [CNT_W-1:0] n_deq_s;
  logic [PTR_W-1:0] wr_idx_s [FETCH_WIDTH];
  logic [PTR_W-1:0] rd_idx_s [DECODE_WIDTH];

  // Free-slot arithmetic is done at 32 bits so margin sums cannot overflow.
  assign free_s                  = 32'(DEPTH) - 32'(count_q);
  assign io_in_ready             = (free_s >= 32'(FETCH_WIDTH));
  assign io_status_back_pressure = (free_s < 32'(BP_MARGIN + FETCH_WIDTH));
  assign io_status_full          = (count_q == CNT_W'(DEPTH));
  assign io_status_count         = count_q;
  assign io_out_valid            = (count_q != CNT_W'(0));

  // Enqueue/dequeue amounts: both clamped, the dequeue also by occupancy.
  always_comb begin
    enq_fire_s = io_in_valid && io_in_ready;
    if (enq_fire_s) begin
      if (32'(io_in_bits_size) < 32'(FETCH_WIDTH)) begin
        n_enq_s = CNT_W'(io_in_bits_size);
      end else begin
        n_enq_s = CNT_W'(FETCH_WIDTH);
      end
    end else begin
      n_enq_s = CNT_W'(0);
    end

    if (32'(io_out_deq_cnt) < 32'(DECODE_WIDTH)) begin
      deq_req_s = 32'(io_out_deq_cnt);
    end else begin
      deq_req_s = 32'(DECODE_WIDTH);
    end

    if (!io_out_valid) begin
      n_deq_s = CNT_W'(0);
    end else if (deq_req_s < 32'(count_q)) begin
      n_deq_s = CNT_W'(deq_req_s);
    end else begin
      n_deq_s = count_q;
    end
  end

  // Slot indices for write lanes and read slots; PTR_W-bit sums wrap mod DEPTH.
  always_comb begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      wr_idx_s[i] = tail_q + PTR_W'(i);
    end
    for (int j = 0; j < DECODE_WIDTH; j++) begin
      rd_idx_s[j] = head_q + PTR_W'(j);
    end
  end

  // Pointer/count next state; flush discards any same-cycle enq/deq.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (io_flush) begin
      head_d  = PTR_W'(0);
      tail_d  = PTR_W'(0);
      count_d = CNT_W'(0);
    end else begin
      head_d  = head_q + PTR_W'(n_deq_s);
      tail_d  = tail_q + PTR_W'(n_enq_s);
      count_d = count_q + n_enq_s - n_deq_s;
    end
  end

  // Pointer/count registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      head_q  <= PTR_W'(0);
      tail_q  <= PTR_W'(0);
      count_q <= CNT_W'(0);
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload write: only the first n_enq lanes land, each with its own PC.
  always_ff @(posedge clock) begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (reset && !io_flush && (CNT_W'(i) < n_enq_s)) begin
        inst_q[wr_idx_s[i]] <= io_in_bits_inst[32*i +: 32];
        pc_q[wr_idx_s[i]]   <= io_in_bits_pc + 32'(4*i);
      end
    end
  end

  // Presentation to the decoder straight from registered state.
  always_comb begin
    io_out_bits_inst  = '0;
    io_out_bits_pc    = '0;
    io_out_bits_valid = '0;
    for (int j = 0; j < DECODE_WIDTH; j++) begin
      io_out_bits_inst[32*j +: 32] = inst_q[rd_idx_s[j]];
      io_out_bits_pc[32*j +: 32]   = pc_q[rd_idx_s[j]];
      io_out_bits_valid[j]         = (32'(count_q) > 32'(j));
    end
  end

  inst_buffer_mw_chk #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .CNT_W (CNT_W)
  ) u_chk (
    .clock_i (clock),
    .reset_i (reset),
    .head_i  (head_q),
    .tail_i  (tail_q),
    .count_i (count_q)
  );

endmodule

// -----------------------------------------------------------------------------
// inst_buffer_mw_chk
// Occupancy invariants of the buffer pointers.
// Ports: clock_i, reset_i (active-low), head_i, tail_i, count_i.
// -----------------------------------------------------------------------------
module inst_buffer_mw_chk #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4,
  parameter int CNT_W = 5
) (
  input logic             clock_i,
  input logic             reset_i,
  input logic [PTR_W-1:0] head_i,
  input logic [PTR_W-1:0] tail_i,
  input logic [CNT_W-1:0] count_i
);

  logic [PTR_W-1:0] span_s;
  assign span_s = tail_i - head_i;

  a_count_bound: assert property (@(posedge clock_i) disable iff (!reset_i)
    32'(count_i) <= 32'(DEPTH));

  // A full buffer has head == tail, so the pointer span reads as zero there.
  a_count_span: assert property (@(posedge clock_i) disable iff (!reset_i)
    ((count_i == CNT_W'(DEPTH)) && (head_i == tail_i)) ||
    (32'(count_i) == 32'(span_s)));

endmodule

// File: tb/tb_inst_buffer_mw.sv
module tb_inst_buffer_mw;

  localparam int FW    = 4;
  localparam int DW    = 4;
  localparam int DEPTH = 16;
  localparam int BP    = 4;

  logic              clock;
  logic              reset;
  logic              io_in_ready;
  logic              io_in_valid;
  logic [FW*32-1:0]  io_in_bits_inst;
  logic [2:0]        io_in_bits_size;
  logic [31:0]       io_in_bits_pc;
  logic              io_out_valid;
  logic [DW*32-1:0]  io_out_bits_inst;
  logic [DW*32-1:0]  io_out_bits_pc;
  logic [DW-1:0]     io_out_bits_valid;
  logic [2:0]        io_out_deq_cnt;
  logic [4:0]        io_status_count;
  logic              io_status_back_pressure;
  logic              io_status_full;
  logic              io_flush;

  inst_buffer_mw #(
    .FETCH_WIDTH (FW),
    .DECODE_WIDTH(DW),
    .DEPTH       (DEPTH),
    .BP_MARGIN   (BP)
  ) dut (
    .clock                  (clock),
    .reset                  (reset),
    .io_in_ready            (io_in_ready),
    .io_in_valid            (io_in_valid),
    .io_in_bits_inst        (io_in_bits_inst),
    .io_in_bits_size        (io_in_bits_size),
    .io_in_bits_pc          (io_in_bits_pc),
    .io_out_valid           (io_out_valid),
    .io_out_bits_inst       (io_out_bits_inst),
    .io_out_bits_pc         (io_out_bits_pc),
    .io_out_bits_valid      (io_out_bits_valid),
    .io_out_deq_cnt         (io_out_deq_cnt),
    .io_status_count        (io_status_count),
    .io_status_back_pressure(io_status_back_pressure),
    .io_status_full         (io_status_full),
    .io_flush               (io_flush)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  ent_t mq[$];
  int   nvec = 0;
  int   nerr = 0;
  bit   cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare every visible output against the queue model.
  task automatic compare();
    int sz;
    logic [DW-1:0] vmask;
    sz = mq.size();
    vmask = '0;
    chk("out_valid", 32'(io_out_valid), 32'(sz != 0));
    chk("in_ready", 32'(io_in_ready), 32'((DEPTH - sz) >= FW));
    chk("count", 32'(io_status_count), 32'(sz));
    chk("back_pressure", 32'(io_status_back_pressure), 32'((DEPTH - sz) < (BP + FW)));
    chk("full", 32'(io_status_full), 32'(sz == DEPTH));
    for (int j = 0; j < DW; j++) begin
      if (j < sz) begin
        vmask[j] = 1'b1;
        chk($sformatf("inst[%0d]", j), io_out_bits_inst[32*j +: 32], mq[j].inst);
        chk($sformatf("pc[%0d]", j), io_out_bits_pc[32*j +: 32], mq[j].pc);
      end
    end
    chk("out_bits_valid", 32'(io_out_bits_valid), 32'(vmask));
  endtask

  // Next model state from the inputs seen at the coming edge.
  task automatic model_step();
    int sz, nd, ne;
    sz = mq.size();
    if (!reset || io_flush) begin
      mq.delete();
    end else begin
      nd = (int'(io_out_deq_cnt) < DW) ? int'(io_out_deq_cnt) : DW;
      if (nd > sz) nd = sz;
      repeat (nd) void'(mq.pop_front());
      if (io_in_valid && ((DEPTH - sz) >= FW)) begin
        ne = (int'(io_in_bits_size) > FW) ? FW : int'(io_in_bits_size);
        for (int i = 0; i < ne; i++) begin
          mq.push_back('{inst: io_in_bits_inst[32*i +: 32], pc: io_in_bits_pc + 32'(4*i)});
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clock);
    if (cmp_en) compare();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] sz, input logic [31:0] pc,
                       input logic [31:0] base, input logic [2:0] deq);
    io_in_valid     = v;
    io_in_bits_size = sz;
    io_in_bits_pc   = pc;
    for (int i = 0; i < FW; i++) io_in_bits_inst[32*i +: 32] = base + 32'(i);
    io_out_deq_cnt  = deq;
  endtask

  initial begin
    reset    = 1'b0;
    io_flush = 1'b0;
    drive(1'b0, 3'd0, 32'h0, 32'h0, 3'd0);
    tick();
    cmp_en = 1'b1;
    tick();
    reset = 1'b1;

    // Reset state
    chk("rst_count", 32'(io_status_count), 32'd0);
    chk("rst_ready", 32'(io_in_ready), 32'd1);
    chk("rst_out_valid", 32'(io_out_valid), 32'd0);
    chk("rst_bits_valid", 32'(io_out_bits_valid), 32'd0);

    // Single enqueue of 3
    drive(1'b1, 3'd3, 32'h1000, 32'h1, 3'd0);
    tick();
    chk("t1_bits_valid", 32'(io_out_bits_valid), 32'h7);
    chk("t1_pc2", io_out_bits_pc[95:64], 32'h1008);
    chk("t1_count", 32'(io_status_count), 32'd3);

    // Partial issue
    drive(1'b1, 3'd3, 32'h100C, 32'h4, 3'd0);
    tick();
    chk("t2_count6", 32'(io_status_count), 32'd6);
    drive(1'b0, 3'd0, 32'h0, 32'h0, 3'd2);
    tick();
    chk("t2_slot0_a", io_out_bits_inst[31:0], 32'h3);
    tick();
    chk("t2_slot0_b", io_out_bits_inst[31:0], 32'h5);
    chk("t2_count2", 32'(io_status_count), 32'd2);
    tick();
    chk("t2_count0", 32'(io_status_count), 32'd0);

    // Fill to full
    drive(1'b1, 3'd4, 32'h5000, 32'h10, 3'd0);
    tick();
    tick();
    chk("t3_bp_at8", 32'(io_status_back_pressure), 32'd0);
    tick();
    chk("t3_bp_at12", 32'(io_status_back_pressure), 32'd1);
    tick();
    chk("t3_full", 32'(io_status_full), 32'd1);
    chk("t3_ready0", 32'(io_in_ready), 32'd0);
    tick();
    chk("t3_count16", 32'(io_status_count), 32'd16);
    drive(1'b0, 3'd0, 32'h0, 32'h0, 3'd4);
    repeat (4) tick();

    // Wrap: bring head/tail to 14, then write slots 14,15,0,1
    drive(1'b1, 3'd4, 32'h6000, 32'h50, 3'd0);
    tick();
    drive(1'b1, 3'd4, 32'h6010, 32'h54, 3'd4);
    tick();
    drive(1'b0, 3'd0, 32'h0, 32'h0, 3'd4);
    tick();
    drive(1'b1, 3'd4, 32'h2000, 32'h20, 3'd0);
    tick();
    chk("t4_pc0", io_out_bits_pc[31:0], 32'h2000);
    chk("t4_pc3", io_out_bits_pc[127:96], 32'h200C);
    chk("t4_inst1", io_out_bits_inst[63:32], 32'h21);

    // Simultaneous enq + deq, then over-request
    drive(1'b1, 3'd4, 32'h3000, 32'h30, 3'd4);
    tick();
    chk("t5_count", 32'(io_status_count), 32'd4);
    chk("t5_pc0", io_out_bits_pc[31:0], 32'h3000);
    drive(1'b1, 3'd4, 32'h4000, 32'h40, 3'd7);
    tick();
    chk("t5_clamp_count", 32'(io_status_count), 32'd4);
    chk("t5_inst3", io_out_bits_inst[127:96], 32'h43);

    // Flush mid-stream with a valid enqueue
    drive(1'b1, 3'd4, 32'h7000, 32'h70, 3'd0);
    tick();
    drive(1'b1, 3'd2, 32'h7010, 32'h74, 3'd0);
    tick();
    chk("t6_count10", 32'(io_status_count), 32'd10);
    io_flush = 1'b1;
    drive(1'b1, 3'd4, 32'h7100, 32'h80, 3'd2);
    tick();
    io_flush = 1'b0;
    chk("t6_flush_count", 32'(io_status_count), 32'd0);
    chk("t6_flush_valid", 32'(io_out_valid), 32'd0);

    // Reset mid-stream with a valid enqueue
    drive(1'b1, 3'd4, 32'h8000, 32'h90, 3'd0);
    tick();
    tick();
    drive(1'b1, 3'd2, 32'h8020, 32'h98, 3'd0);
    tick();
    reset = 1'b0;
    drive(1'b1, 3'd4, 32'h8100, 32'hA0, 3'd1);
    tick();
    reset = 1'b1;
    chk("t7_rst_count", 32'(io_status_count), 32'd0);
    chk("t7_rst_valid", 32'(io_out_valid), 32'd0);

    // Boundary sizes and empty dequeue
    drive(1'b0, 3'd0, 32'h0, 32'h0, 3'd3);
    tick();
    chk("t8_empty_deq", 32'(io_status_count), 32'd0);
    drive(1'b1, 3'd0, 32'h9000, 32'hB0, 3'd0);
    tick();
    chk("t8_size0", 32'(io_status_count), 32'd0);
    drive(1'b1, 3'd7, 32'hFFFF_FFF8, 32'hC0, 3'd0);
    tick();
    chk("t8_size7", 32'(io_status_count), 32'd4);
    chk("t8_pc_wrap", io_out_bits_pc[127:96], 32'h0000_0004);

    // Mixed deterministic traffic
    for (int k = 0; k < 40; k++) begin
      io_flush = (k == 25);
      drive((k % 3) != 2, 3'(k % 6), 32'hA000 + 32'(k * 64), 32'h100 + 32'(k * 8), 3'((k * 5) % 8));
      tick();
    end
    io_flush = 1'b0;
    drive(1'b0, 3'd0, 32'h0, 32'h0, 3'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
